// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: requester indices, source enum and the broadcast result record.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

    localparam int CDB_N_UNITS  = 5;
    localparam int CDB_BR_IDX   = 0;
    localparam int CDB_DIV_IDX  = 1;
    localparam int CDB_MULT_IDX = 2;
    localparam int CDB_MEM_IDX  = 3;
    localparam int CDB_ALU_IDX  = 4;
    localparam int CDB_SRC_W    = $clog2(CDB_N_UNITS);

    typedef enum logic [CDB_SRC_W-1:0] {
        CDB_SRC_BR   = 3'd0,
        CDB_SRC_DIV  = 3'd1,
        CDB_SRC_MULT = 3'd2,
        CDB_SRC_MEM  = 3'd3,
        CDB_SRC_ALU  = 3'd4
    } cdb_src_e;

    typedef struct packed {
        logic        valid;
        logic [5:0]  rob_id;
        logic [5:0]  prd;
        logic [31:0] rd_data;
        logic [31:0] pc_next;
        logic        br_miss;
        logic        br_en;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
    } cdb_output_t;

    // Next round-robin candidate; the branch slot is never part of the rotation.
    function automatic logic [CDB_SRC_W-1:0] cdb_rr_next(input logic [CDB_SRC_W-1:0] k);
        return (k == CDB_SRC_W'(CDB_N_UNITS - 1)) ? CDB_SRC_W'(CDB_DIV_IDX) : k + CDB_SRC_W'(1);
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-unit result queue holding DEPTH cdb_output_t entries.
// Latency: an entry pushed at an edge is visible at head from the next cycle.
// Backpressure: full is asserted at DEPTH entries; clear empties it at the edge.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  cdb_output_t                  din,
    output logic                         full,
    output logic                         empty,
    output cdb_output_t                  head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cdb_output_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffered CDB scheduler: branch has strict priority, other units share the bus round-robin.
// Latency: a result pushed at edge t is broadcast at the earliest in the cycle after t.
// Backpressure: unit_ready drops only when that unit's FIFO is full, or for the whole flush cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  cdb_output_t                  unit_info    [CDB_N_UNITS],
    output logic [CDB_N_UNITS-1:0]       unit_ready,
    output cdb_output_t                  cdb_output,
    output logic [CDB_N_UNITS-1:0]       grant_onehot,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count   [CDB_N_UNITS]
);

    logic [CDB_N_UNITS-1:0] push;
    logic [CDB_N_UNITS-1:0] full;
    logic [CDB_N_UNITS-1:0] empty;
    cdb_output_t            head [CDB_N_UNITS];

    logic [CDB_SRC_W-1:0]   rr_ptr;
    logic [CDB_SRC_W-1:0]   grant_idx;
    logic [CDB_SRC_W-1:0]   cand;
    logic                   grant_any;

    for (genvar i = 0; i < CDB_N_UNITS; i++) begin : g_unit
        assign unit_ready[i] = !flush && !full[i];
        assign push[i]       = unit_info[i].valid && unit_ready[i];

        cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (grant_onehot[i]),
            .clear (flush),
            .din   (unit_info[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i]),
            .count (fifo_count[i])
        );
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = rr_ptr;
        if (!empty[CDB_BR_IDX]) begin
            grant_any = 1'b1;
            grant_idx = CDB_SRC_W'(CDB_BR_IDX);
        end else begin
            for (int k = 0; k < CDB_N_UNITS - 1; k++) begin
                if (!grant_any && !empty[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
                cand = cdb_rr_next(cand);
            end
        end
    end

    // Only the branch unit may drive redirect fields and only mem may drive mem fields.
    always_comb begin
        cdb_output   = '0;
        grant_onehot = '0;
        if (grant_any && !flush) begin
            grant_onehot[grant_idx] = 1'b1;
            cdb_output              = head[grant_idx];
            cdb_output.valid        = 1'b1;
            if (grant_idx != CDB_SRC_W'(CDB_BR_IDX)) begin
                cdb_output.pc_next = '0;
                cdb_output.br_miss = 1'b0;
                cdb_output.br_en   = 1'b0;
            end
            if (grant_idx != CDB_SRC_W'(CDB_MEM_IDX)) begin
                cdb_output.mem_addr  = '0;
                cdb_output.mem_rmask = '0;
                cdb_output.mem_wmask = '0;
                cdb_output.mem_wdata = '0;
                cdb_output.mem_rdata = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rr_ptr <= CDB_SRC_W'(CDB_DIV_IDX);
        end else if (grant_any && grant_idx != CDB_SRC_W'(CDB_BR_IDX)) begin
            rr_ptr <= cdb_rr_next(grant_idx);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run
// against a queue-based model of the scheduling rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int NU    = CDB_N_UNITS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    cdb_output_t          unit_info   [NU];
    logic [NU-1:0]        unit_ready;
    cdb_output_t          cdb_output;
    logic [NU-1:0]        grant_onehot;
    logic [1:0]           fifo_count  [NU];

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .unit_info    (unit_info),
        .unit_ready   (unit_ready),
        .cdb_output   (cdb_output),
        .grant_onehot (grant_onehot),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NU; i++) unit_info[i] = '0;
    endtask

    function automatic cdb_output_t mk(input int rob);
        cdb_output_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.rob_id    = 6'(rob);
        r.prd       = 6'(rob + 1);
        r.rd_data   = 32'hD000_0000 + 32'(rob);
        r.pc_next   = 32'h1000_0000 + 32'(rob);
        r.br_miss   = 1'b1;
        r.br_en     = 1'b1;
        r.mem_addr  = 32'hA000_0000 + 32'(rob);
        r.mem_rmask = 4'h3;
        r.mem_wmask = 4'hC;
        r.mem_wdata = 32'hBEEF_0000 + 32'(rob);
        r.mem_rdata = 32'hCAFE_0000 + 32'(rob);
        return r;
    endfunction

    // What the bus should show for source record s coming from unit idx.
    function automatic cdb_output_t expect_out(input cdb_output_t s, input int idx);
        cdb_output_t e;
        e       = s;
        e.valid = 1'b1;
        if (idx != 0) begin
            e.pc_next = '0;
            e.br_miss = 1'b0;
            e.br_en   = 1'b0;
        end
        if (idx != 3) begin
            e.mem_addr  = '0;
            e.mem_rmask = '0;
            e.mem_wmask = '0;
            e.mem_wdata = '0;
            e.mem_rdata = '0;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < NU; i++) unit_info[i] = mk(i + 1);
        tick();
        tick();
        @(negedge clk);
        total++;
        if (cdb_output !== '0) begin
            $display("FAIL reset_out got=%h exp=0", cdb_output); bad++;
        end
        total++;
        if (grant_onehot !== '0) begin
            $display("FAIL reset_grant got=%b exp=00000", grant_onehot); bad++;
        end
        for (int i = 0; i < NU; i++) begin
            total++;
            if (fifo_count[i] !== 2'd0) begin
                $display("FAIL reset_count[%0d] got=%0d exp=0", i, fifo_count[i]); bad++;
            end
        end
        rst_n = 1'b1;
        idle_inputs();
        #1;
        total++;
        if (unit_ready !== 5'b11111) begin
            $display("FAIL reset_ready got=%b exp=11111", unit_ready); bad++;
        end
        tick();
    endtask

    task automatic test_single();
        cdb_output_t e;
        unit_info[4] = mk(7);
        @(negedge clk);
        total++;
        if (grant_onehot !== '0) begin
            $display("FAIL single_nobypass got=%b exp=00000", grant_onehot); bad++;
        end
        tick();
        idle_inputs();
        @(negedge clk);
        e = expect_out(mk(7), 4);
        total++;
        if (cdb_output !== e) begin
            $display("FAIL single_out got=%h exp=%h", cdb_output, e); bad++;
        end
        total++;
        if (grant_onehot !== 5'b10000) begin
            $display("FAIL single_grant got=%b exp=10000", grant_onehot); bad++;
        end
        tick();
        @(negedge clk);
        total++;
        if (grant_onehot !== '0 || cdb_output !== '0) begin
            $display("FAIL single_idle got=%b/%h exp=00000/0", grant_onehot, cdb_output); bad++;
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [NU-1:0] eg;
        for (int rep = 0; rep < 2; rep++) begin
            for (int u = 1; u < NU; u++) unit_info[u] = mk(20 + 10 * rep + u);
            tick();
            idle_inputs();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                eg = '0;
                eg[k + 1] = 1'b1;
                total++;
                if (grant_onehot !== eg || cdb_output !== expect_out(mk(20 + 10 * rep + k + 1), k + 1)) begin
                    $display("FAIL rr_order rep=%0d slot=%0d got=%b rob=%0d exp=%b rob=%0d",
                             rep, k, grant_onehot, cdb_output.rob_id, eg, 20 + 10 * rep + k + 1);
                    bad++;
                end
                tick();
            end
        end
    endtask

    task automatic test_branch_priority();
        cdb_output_t b;
        b         = mk(22);
        b.pc_next = 32'h8000_0040;
        b.br_miss = 1'b1;
        unit_info[4] = mk(21);
        unit_info[0] = b;
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (grant_onehot !== 5'b00001 || cdb_output.pc_next !== 32'h8000_0040 ||
            cdb_output.br_miss !== 1'b1 || cdb_output.rob_id !== 6'd22) begin
            $display("FAIL br_first got=%b pc=%h miss=%b rob=%0d exp=00001 pc=80000040 miss=1 rob=22",
                     grant_onehot, cdb_output.pc_next, cdb_output.br_miss, cdb_output.rob_id);
            bad++;
        end
        tick();
        @(negedge clk);
        total++;
        if (grant_onehot !== 5'b10000 || cdb_output.br_miss !== 1'b0 || cdb_output.rob_id !== 6'd21) begin
            $display("FAIL br_then_alu got=%b miss=%b rob=%0d exp=10000 miss=0 rob=21",
                     grant_onehot, cdb_output.br_miss, cdb_output.rob_id);
            bad++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // Expected per cycle: mult ready, grant vector, mult rob on the bus (0 = don't check)
        logic [2:0]    br_rob   [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        logic          m_vld    [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic [5:0]    m_rob    [8] = '{30, 31, 32, 32, 32, 32, 0, 0};
        logic          exp_rdy  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic [NU-1:0] exp_g    [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001,
                                        5'b00100, 5'b00100, 5'b00100, 5'b00000};
        logic [5:0]    exp_rob  [8] = '{0, 0, 0, 0, 30, 31, 32, 0};
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            if (br_rob[c] != 0) unit_info[0] = mk(50 + int'(br_rob[c]));
            if (m_vld[c]) unit_info[2] = mk(int'(m_rob[c]));
            @(negedge clk);
            total++;
            if (unit_ready[2] !== exp_rdy[c]) begin
                $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, unit_ready[2], exp_rdy[c]); bad++;
            end
            total++;
            if (grant_onehot !== exp_g[c] || (exp_rob[c] != 0 && cdb_output.rob_id !== exp_rob[c])) begin
                $display("FAIL bp_grant cyc=%0d got=%b rob=%0d exp=%b rob=%0d",
                         c, grant_onehot, cdb_output.rob_id, exp_g[c], exp_rob[c]);
                bad++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        for (int i = 0; i < NU; i++) unit_info[i] = mk(40 + i);
        tick();
        for (int i = 0; i < NU; i++) unit_info[i] = mk(50 + i);
        tick();
        flush = 1'b1;
        for (int i = 0; i < NU; i++) unit_info[i] = mk(60 + i);
        @(negedge clk);
        total++;
        if (cdb_output !== '0 || grant_onehot !== '0 || unit_ready !== '0) begin
            $display("FAIL flush_cycle got out=%h g=%b rdy=%b exp=0/0/0", cdb_output, grant_onehot, unit_ready);
            bad++;
        end
        tick();
        flush = 1'b0;
        idle_inputs();
        @(negedge clk);
        for (int i = 0; i < NU; i++) begin
            total++;
            if (fifo_count[i] !== 2'd0) begin
                $display("FAIL flush_count[%0d] got=%0d exp=0", i, fifo_count[i]); bad++;
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (cdb_output.valid !== 1'b0 || grant_onehot !== '0) begin
                $display("FAIL flush_stale cyc=%0d got v=%b g=%b rob=%0d exp=0", c,
                         cdb_output.valid, grant_onehot, cdb_output.rob_id);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        cdb_output_t    q [NU][$];
        int             rr;
        int             win;
        int             c;
        cdb_output_t    exp_out;
        logic [NU-1:0]  exp_g;
        logic [NU-1:0]  exp_rdy;
        logic [191:0]   r;
        // Align DUT with an empty model: flush clears queues and the rotation.
        flush = 1'b1;
        idle_inputs();
        tick();
        flush = 1'b0;
        rr = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom_range(99) != 0);
            flush = ($urandom_range(49) == 0);
            for (int i = 0; i < NU; i++) begin
                r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                unit_info[i]       = r[$bits(cdb_output_t)-1:0];
                unit_info[i].valid = ($urandom_range(99) < 55);
            end
            @(negedge clk);
            win = -1;
            if (q[0].size() > 0) begin
                win = 0;
            end else begin
                for (int k = 0; k < NU - 1; k++) begin
                    c = ((rr - 1 + k) % (NU - 1)) + 1;
                    if (win < 0 && q[c].size() > 0) win = c;
                end
            end
            exp_out = '0;
            exp_g   = '0;
            if (!flush && win >= 0) begin
                exp_out    = expect_out(q[win][0], win);
                exp_g[win] = 1'b1;
            end
            for (int i = 0; i < NU; i++) exp_rdy[i] = !flush && (q[i].size() < DEPTH);
            total++;
            if (cdb_output !== exp_out) begin
                $display("FAIL rnd_out cyc=%0d got=%h exp=%h", cyc, cdb_output, exp_out); bad++;
            end
            total++;
            if (grant_onehot !== exp_g) begin
                $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, grant_onehot, exp_g); bad++;
            end
            total++;
            if (unit_ready !== exp_rdy) begin
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, unit_ready, exp_rdy); bad++;
            end
            for (int i = 0; i < NU; i++) begin
                total++;
                if (fifo_count[i] !== 2'(q[i].size())) begin
                    $display("FAIL rnd_count[%0d] cyc=%0d got=%0d exp=%0d", i, cyc, fifo_count[i], q[i].size());
                    bad++;
                end
            end
            if (!rst_n || flush) begin
                for (int i = 0; i < NU; i++) q[i].delete();
                rr = 1;
            end else begin
                if (win >= 0) begin
                    void'(q[win].pop_front());
                    if (win != 0) rr = (win % (NU - 1)) + 1;
                end
                for (int i = 0; i < NU; i++)
                    if (unit_info[i].valid && exp_rdy[i]) q[i].push_back(unit_info[i]);
            end
            tick();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_branch_priority();
        test_back_to_back();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
